// File: rtl/eth_tx_arb_pkg.sv
// Shared types and width helpers for the eth_tx application arbiter.
// Holds the arbiter state encoding and the default widths for the datapath.
package eth_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_DRAIN,
    ST_GAP
  } arb_state_e;

  localparam int DEF_REQ_N     = 2;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_PKT_LEN_W = 16;
  localparam int DEF_UDP_CS_W  = 16;
  localparam int DEF_IPG_CYC   = 2;

  // Gap counter width; it never drops below 1 bit, even when no gap is configured.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_app_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr,
// with wrap-around, returned as a one-hot vector and as an index.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    logic w_found;
    int   j;
    // NOTE: every output gets a default before the loop, so no path leaves a latch.
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    j        = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[j]) begin
        w_found     = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/eth_tx_app_arb.sv
// Round-robin arbiter sharing one eth_tx pipe between REQ_N application streams:
// grant, early start, data mux until last beat, CRC drain, then inter-packet gap.
module eth_tx_app_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int REQ_N          = DEF_REQ_N,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int KEEP_W         = DATA_W / 8,
  parameter int LEN_W          = $clog2(KEEP_W + 1),
  parameter int PKT_LEN_W      = DEF_PKT_LEN_W,
  parameter int UDP_CS_W       = DEF_UDP_CS_W,
  parameter int APP_LAST_LEN_W = $clog2(8 + KEEP_W + 1),
  parameter int IPG_CYC        = DEF_IPG_CYC
) (
  input  logic                              clk,
  input  logic                              nreset,
  input  logic [REQ_N-1:0]                  req_i,
  input  logic [REQ_N*PKT_LEN_W-1:0]        req_pkt_len_i,
  input  logic [REQ_N*UDP_CS_W-1:0]         req_cs_i,
  input  logic [REQ_N-1:0]                  req_cancel_i,
  input  logic [REQ_N*DATA_W-1:0]           req_data_i,
  input  logic [REQ_N*LEN_W-1:0]            req_len_i,
  input  logic [REQ_N-1:0]                  req_last_i,
  input  logic [REQ_N-1:0]                  req_last_block_next_i,
  input  logic [REQ_N*APP_LAST_LEN_W-1:0]   req_last_block_next_len_i,
  output logic [REQ_N-1:0]                  grant_o,
  output logic [REQ_N-1:0]                  ready_o,
  output logic [REQ_N-1:0]                  done_o,
  output logic                              tx_early_v_o,
  output logic                              tx_cancel_o,
  output logic [PKT_LEN_W-1:0]              tx_pkt_len_o,
  output logic [UDP_CS_W-1:0]               tx_cs_o,
  output logic [DATA_W-1:0]                 tx_data_o,
  output logic [LEN_W-1:0]                  tx_len_o,
  output logic                              tx_last_o,
  output logic                              tx_last_block_next_o,
  output logic [APP_LAST_LEN_W-1:0]         tx_last_block_next_len_o,
  input  logic                              tx_ready_v_i,
  input  logic                              tx_idle_i
);

  localparam int IDX_W = $clog2(REQ_N);
  localparam int CNT_W = cnt_width(IPG_CYC);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((IPG_CYC > 0) ? IPG_CYC - 1 : 0);

  arb_state_e           r_state;
  logic [REQ_N-1:0]     r_grant;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_ptr;
  logic [PKT_LEN_W-1:0] r_pkt_len;
  logic [UDP_CS_W-1:0]  r_cs;
  logic                 r_early_v;
  logic [CNT_W-1:0]     r_gap_cnt;

  logic [REQ_N-1:0]          w_pick_oh;
  logic [IDX_W-1:0]          w_pick_idx;
  logic                      w_send, w_in_pkt, w_own_cancel, w_cancel, w_done, w_finish;
  logic [DATA_W-1:0]         w_data;
  logic [LEN_W-1:0]          w_len;
  logic                      w_last, w_lbn;
  logic [APP_LAST_LEN_W-1:0] w_lbn_len;

  rr_pick #(.N(REQ_N), .IDX_W(IDX_W)) u_rr_pick (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  // AND-OR mux of the owner's stream; r_grant is one-hot or zero.
  always_comb begin
    w_data    = '0;
    w_len     = '0;
    w_last    = 1'b0;
    w_lbn     = 1'b0;
    w_lbn_len = '0;
    for (int r = 0; r < REQ_N; r++) begin
      w_data    |= req_data_i[r*DATA_W +: DATA_W] & {DATA_W{r_grant[r]}};
      w_len     |= req_len_i[r*LEN_W +: LEN_W] & {LEN_W{r_grant[r]}};
      w_last    |= req_last_i[r] & r_grant[r];
      w_lbn     |= req_last_block_next_i[r] & r_grant[r];
      w_lbn_len |= req_last_block_next_len_i[r*APP_LAST_LEN_W +: APP_LAST_LEN_W]
                   & {APP_LAST_LEN_W{r_grant[r]}};
    end
  end

  assign w_send       = (r_state == ST_SEND);
  assign w_in_pkt     = (r_state == ST_START) || w_send || (r_state == ST_DRAIN);
  assign w_own_cancel = |(req_cancel_i & r_grant);
  assign w_cancel     = w_in_pkt & w_own_cancel;
  assign w_done       = (r_state == ST_DRAIN) & tx_idle_i & ~w_own_cancel;
  assign w_finish     = w_cancel | w_done;

  assign grant_o                  = r_grant;
  assign ready_o                  = r_grant & {REQ_N{w_send & tx_ready_v_i}};
  assign done_o                   = r_grant & {REQ_N{nreset & w_done}};
  assign tx_early_v_o             = r_early_v;
  assign tx_cancel_o              = nreset & w_cancel;
  assign tx_pkt_len_o             = r_pkt_len;
  assign tx_cs_o                  = r_cs;
  assign tx_data_o                = w_data & {DATA_W{w_send}};
  assign tx_len_o                 = w_len & {LEN_W{w_send}};
  assign tx_last_o                = w_last & w_send;
  assign tx_last_block_next_o     = w_lbn & w_send;
  assign tx_last_block_next_len_o = w_lbn_len & {APP_LAST_LEN_W{w_send}};

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_ptr     <= IDX_W'(REQ_N - 1);
      r_pkt_len <= '0;
      r_cs      <= '0;
      r_early_v <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_early_v <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (|req_i) begin
            r_grant   <= w_pick_oh;
            r_owner   <= w_pick_idx;
            r_pkt_len <= req_pkt_len_i[w_pick_idx*PKT_LEN_W +: PKT_LEN_W];
            r_cs      <= req_cs_i[w_pick_idx*UDP_CS_W +: UDP_CS_W];
            r_early_v <= 1'b1;
            r_state   <= ST_START;
          end
        end
        ST_START: if (!w_own_cancel) r_state <= ST_SEND;
        ST_SEND:  if (!w_own_cancel && w_last && tx_ready_v_i) r_state <= ST_DRAIN;
        ST_DRAIN: ;
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) r_state <= ST_IDLE;
          else r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Done or cancel releases the pipe; the owner becomes the lowest-priority requester.
      if (w_finish) begin
        r_grant   <= '0;
        r_ptr     <= r_owner;
        r_gap_cnt <= '0;
        if (IPG_CYC == 0) r_state <= ST_IDLE;
        else r_state <= ST_GAP;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_app_arb.sv
// Bench for eth_tx_app_arb: two instances (IPG_CYC=2 and IPG_CYC=0) share the
// stimulus, each compared every cycle against a packet-level reference model.
module tb_eth_tx_app_arb;

  localparam int NDUT = 2;
  localparam int REQ_N = 2;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [1:0]  req_i = '0, req_cancel_i = '0, req_last_i = '0, req_last_block_next_i = '0;
  logic [31:0] req_pkt_len_i = '0, req_cs_i = '0, req_data_i = '0;
  logic [3:0]  req_len_i = '0;
  logic [7:0]  req_last_block_next_len_i = '0;
  logic        tx_ready_v_i = 1'b0, tx_idle_i = 1'b0;

  logic [1:0]  grant_o [NDUT];
  logic [1:0]  ready_o [NDUT];
  logic [1:0]  done_o [NDUT];
  logic        tx_early_v_o [NDUT];
  logic        tx_cancel_o [NDUT];
  logic [15:0] tx_pkt_len_o [NDUT];
  logic [15:0] tx_cs_o [NDUT];
  logic [15:0] tx_data_o [NDUT];
  logic [1:0]  tx_len_o [NDUT];
  logic        tx_last_o [NDUT];
  logic        tx_last_block_next_o [NDUT];
  logic [3:0]  tx_last_block_next_len_o [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    eth_tx_app_arb #(.IPG_CYC(g == 0 ? 2 : 0)) u_dut (
      .clk                       (clk),
      .nreset                    (nreset),
      .req_i                     (req_i),
      .req_pkt_len_i             (req_pkt_len_i),
      .req_cs_i                  (req_cs_i),
      .req_cancel_i              (req_cancel_i),
      .req_data_i                (req_data_i),
      .req_len_i                 (req_len_i),
      .req_last_i                (req_last_i),
      .req_last_block_next_i     (req_last_block_next_i),
      .req_last_block_next_len_i (req_last_block_next_len_i),
      .grant_o                   (grant_o[g]),
      .ready_o                   (ready_o[g]),
      .done_o                    (done_o[g]),
      .tx_early_v_o              (tx_early_v_o[g]),
      .tx_cancel_o               (tx_cancel_o[g]),
      .tx_pkt_len_o              (tx_pkt_len_o[g]),
      .tx_cs_o                   (tx_cs_o[g]),
      .tx_data_o                 (tx_data_o[g]),
      .tx_len_o                  (tx_len_o[g]),
      .tx_last_o                 (tx_last_o[g]),
      .tx_last_block_next_o      (tx_last_block_next_o[g]),
      .tx_last_block_next_len_o  (tx_last_block_next_len_o[g]),
      .tx_ready_v_i              (tx_ready_v_i),
      .tx_idle_i                 (tx_idle_i)
    );
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the pipe, how long since the grant, whether the
  // last beat has gone, and how many gap cycles remain before sampling again.
  int          m_owner [NDUT];
  int          m_ptr [NDUT];
  int          m_age [NDUT];
  int          m_gap [NDUT];
  bit          m_drain [NDUT];
  logic [15:0] m_len [NDUT];
  logic [15:0] m_cs [NDUT];

  task automatic model_reset(input int k);
    m_owner[k] = -1;
    m_ptr[k]   = REQ_N - 1;
    m_age[k]   = 0;
    m_gap[k]   = 0;
    m_drain[k] = 1'b0;
    m_len[k]   = '0;
    m_cs[k]    = '0;
  endtask

  task automatic model_eval(input int k);
    int o, os, ipg, win;
    logic [1:0] e_grant;
    logic e_early, e_send, e_cancel, e_done;
    ipg     = (k == 0) ? 2 : 0;
    o       = m_owner[k];
    os      = (o < 0) ? 0 : o;
    e_grant = (o < 0) ? 2'b00 : 2'(1 << o);
    e_early = (o >= 0) && (m_age[k] == 0);
    e_send  = (o >= 0) && (m_age[k] > 0) && !m_drain[k];
    e_cancel = nreset && (o >= 0) && req_cancel_i[os];
    e_done  = nreset && (o >= 0) && m_drain[k] && tx_idle_i && !e_cancel;

    check($sformatf("grant[%0d]", k), grant_o[k], e_grant);
    check($sformatf("ready[%0d]", k), ready_o[k], (e_send && tx_ready_v_i) ? e_grant : 2'b00);
    check($sformatf("done[%0d]", k), done_o[k], e_done ? e_grant : 2'b00);
    check($sformatf("early[%0d]", k), tx_early_v_o[k], e_early);
    check($sformatf("cancel[%0d]", k), tx_cancel_o[k], e_cancel);
    check($sformatf("pkt_len[%0d]", k), tx_pkt_len_o[k], m_len[k]);
    check($sformatf("cs[%0d]", k), tx_cs_o[k], m_cs[k]);
    check($sformatf("data[%0d]", k), tx_data_o[k], e_send ? req_data_i[os*16 +: 16] : 16'h0);
    check($sformatf("len[%0d]", k), tx_len_o[k], e_send ? req_len_i[os*2 +: 2] : 2'h0);
    check($sformatf("last[%0d]", k), tx_last_o[k], e_send && req_last_i[os]);
    check($sformatf("lbn[%0d]", k), tx_last_block_next_o[k], e_send && req_last_block_next_i[os]);
    check($sformatf("lbn_len[%0d]", k), tx_last_block_next_len_o[k],
          e_send ? req_last_block_next_len_i[os*4 +: 4] : 4'h0);

    if (!nreset) begin
      model_reset(k);
    end else if (o >= 0) begin
      if (e_cancel || e_done) begin
        m_ptr[k]   = o;
        m_owner[k] = -1;
        m_gap[k]   = ipg;
      end else begin
        if (e_send && req_last_i[o] && tx_ready_v_i) m_drain[k] = 1'b1;
        m_age[k]++;
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end else if (req_i != 2'b00) begin
      win = -1;
      for (int i = 1; i <= REQ_N; i++)
        if (win < 0 && req_i[(m_ptr[k] + i) % REQ_N]) win = (m_ptr[k] + i) % REQ_N;
      m_owner[k] = win;
      m_age[k]   = 0;
      m_drain[k] = 1'b0;
      m_len[k]   = req_pkt_len_i[win*16 +: 16];
      m_cs[k]    = req_cs_i[win*16 +: 16];
    end
  endtask

  // One clock: drive inputs just after the rising edge, check on the falling edge.
  task automatic run_cycle(input logic rst_n, input logic [1:0] req, input logic [1:0] cancel,
                           input logic [1:0] last, input logic rdy, input logic idl,
                           input logic [31:0] plen);
    @(posedge clk);
    #1;
    nreset                    = rst_n;
    req_i                     = req;
    req_cancel_i              = cancel;
    req_last_i                = last;
    tx_ready_v_i              = rdy;
    tx_idle_i                 = idl;
    req_pkt_len_i             = plen;
    req_cs_i                  = $urandom;
    req_data_i                = $urandom;
    req_len_i                 = 4'($urandom);
    req_last_block_next_i     = 2'($urandom);
    req_last_block_next_len_i = 8'($urandom);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) model_eval(k);
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) model_reset(k);
    repeat (3) run_cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
    check("reset_grant", grant_o[0], 2'b00);

    // Single packet from requester 0, length 46, last on the third accepted beat.
    run_cycle(1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 32'd46);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd46);
    check("t1_grant", grant_o[0], 2'b01);
    check("t1_early", tx_early_v_o[0], 1'b1);
    check("t1_pkt_len", tx_pkt_len_o[0], 16'd46);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 32'd46);
    check("t1_early_once", tx_early_v_o[0], 1'b0);
    check("t1_ready", ready_o[0], 2'b01);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 32'd46);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd46);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 32'd46);
    check("t1_last", tx_last_o[0], 1'b1);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd46);
    check("t1_no_done_busy", done_o[0], 2'b00);
    check("t1_drain_data", tx_data_o[0], 16'h0);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'd46);
    check("t1_done", done_o[0], 2'b01);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd46);
    check("t1_released", grant_o[0], 2'b00);
    repeat (4) run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);

    // Requester 1 reaches DRAIN, then reset drops the packet; pointer returns to favour 0.
    run_cycle(1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
    check("t5_grant", grant_o[0], 2'b10);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 32'd0);
    run_cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
    run_cycle(1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
    check("t5_grant_cleared", grant_o[0], 2'b00);
    check("t5_done_none", done_o[0], 2'b00);
    run_cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
    check("t5_regrant0_ipg2", grant_o[0], 2'b01);
    check("t5_regrant0_ipg0", grant_o[1], 2'b01);

    // Random traffic: contention, cancels from owner and non-owner, stray last, reset.
    for (int c = 0; c < 3000; c++) begin
      run_cycle(1'b1 ^ ($urandom_range(199) == 0),
                2'($urandom),
                {($urandom_range(24) == 0), ($urandom_range(24) == 0)},
                {($urandom_range(3) == 0), ($urandom_range(3) == 0)},
                ($urandom_range(3) != 0),
                ($urandom_range(1) == 0),
                $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
